// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: default depth, feeder FSM
// encodings and a saturating counter helper.
package uart_pkg;

    localparam int DEPTH_DEF = 16;

    // Sparse encoding so the unused codes can be recovered to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_WAIT_ACT  = 3'b001,
        S_WAIT_DONE = 3'b010,
        S_GAP       = 3'b100
    } tx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'h01;
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-push / transmitter handshake bundle for uart_tx_fifo.
// o_Ovf_Count exists only when UART_TX_FIFO_OVF_CNT_EN is defined.
interface uart_tx_fifo_if import uart_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic          i_Wr_En;
    logic [7:0]    i_Wr_Byte;
    logic          o_Full;
    logic          o_Empty;
    logic [AW:0]   o_Count;
    logic          o_Tx_DV;
    logic [7:0]    o_Tx_Byte;
    logic          i_Tx_Active;
    logic          i_Tx_Done;
    logic          o_Busy;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0]    o_Ovf_Count;
`endif

    modport master (
`ifdef UART_TX_FIFO_OVF_CNT_EN
        input  o_Ovf_Count,
`endif
        output i_Wr_En, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte, o_Busy
    );

    modport slave (
`ifdef UART_TX_FIFO_OVF_CNT_EN
        output o_Ovf_Count,
`endif
        input  i_Wr_En, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte, o_Busy
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte FIFO storage with AW+1-bit wrap pointers, one write port and one
// registered read port; flags and count are registered from next pointers.
module uart_fifo_mem import uart_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] count_r;
    logic        full_r;
    logic        empty_r;
    logic [7:0]  rd_data_r;

    logic        push_s;
    logic        pop_s;
    logic [AW:0] wr_ptr_nxt_s;
    logic [AW:0] rd_ptr_nxt_s;
    logic [AW:0] count_nxt_s;
    logic        full_nxt_s;
    logic        empty_nxt_s;

    // Accept/pop qualification against registered flags and next-state flags
    always_comb begin
        push_s       = wr_en && !full_r;
        pop_s        = rd_en && !empty_r;
        wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        full_nxt_s   = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                       (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
        empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Pointer, flag and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= full_nxt_s;
            empty_r  <= empty_nxt_s;
        end
    end

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Registered read port, holds the last popped byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 8'h00;
        end else if (pop_s) begin
            rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that feeds a UART transmitter one byte at a time.
// Define UART_TX_FIFO_OVF_CNT_EN to add the saturating dropped-push counter.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           osc_clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    tx_state_e   state_r;
    tx_state_e   state_nxt_s;
    logic        pop_s;
    logic        tx_dv_r;
    logic        busy_r;
    logic        full_s;
    logic        empty_s;
    logic [AW:0] count_s;
    logic [7:0]  tx_byte_s;

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (osc_clk),
        .rst_n   (rst_n),
        .wr_en   (bus.i_Wr_En),
        .wr_data (bus.i_Wr_Byte),
        .rd_en   (pop_s),
        .rd_data (tx_byte_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Feeder state register
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: S_GAP waits for Done to fall so a long Done starts nothing
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (!empty_s && !bus.i_Tx_Active && !bus.i_Tx_Done) state_nxt_s = S_WAIT_ACT;
                else                                                 state_nxt_s = S_IDLE;
            end
            S_WAIT_ACT: begin
                if (bus.i_Tx_Active) state_nxt_s = S_WAIT_DONE;
                else                 state_nxt_s = S_WAIT_ACT;
            end
            S_WAIT_DONE: begin
                if (bus.i_Tx_Done) state_nxt_s = S_GAP;
                else               state_nxt_s = S_WAIT_DONE;
            end
            S_GAP: begin
                if (!bus.i_Tx_Done) state_nxt_s = S_IDLE;
                else                state_nxt_s = S_GAP;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Pop decision: only from S_IDLE with data and a quiet transmitter
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!empty_s && !bus.i_Tx_Active && !bus.i_Tx_Done) pop_s = 1'b1;
                else                                                 pop_s = 1'b0;
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Registered start pulse and busy flag
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_dv_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            tx_dv_r <= pop_s;
            busy_r  <= (state_nxt_s != S_IDLE);
        end
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_r;

    // Count pushes dropped against the registered full flag
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_r <= 8'h00;
        end else if (bus.i_Wr_En && full_s) begin
            ovf_cnt_r <= sat_inc8(ovf_cnt_r);
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign bus.o_Ovf_Count = ovf_cnt_r;
`endif

    assign bus.o_Full    = full_s;
    assign bus.o_Empty   = empty_s;
    assign bus.o_Count   = count_s;
    assign bus.o_Tx_DV   = tx_dv_r;
    assign bus.o_Tx_Byte = tx_byte_s;
    assign bus.o_Busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic osc_clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic model_en     = 1'b0;
    logic model_active = 1'b0;
    logic model_done   = 1'b0;
    logic man_active   = 1'b0;
    logic man_done     = 1'b0;
    int   model_len    = 4;
    int   mcnt         = 0;
    int   dcnt         = 0;

    int         dv_total   = 0;
    int         viol_total = 0;
    int         long_total = 0;
    logic       dv_prev    = 1'b0;
    logic [7:0] byte_log [128];

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .osc_clk (osc_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 osc_clk = ~osc_clk;

    assign bus.i_Tx_Active = model_en ? model_active : man_active;
    assign bus.i_Tx_Done   = model_en ? model_done   : man_done;

    // Transmitter model: Active for model_len cycles after DV, then Done for 2 cycles
    always @(posedge osc_clk) begin
        if (!model_en) begin
            model_active <= 1'b0;
            model_done   <= 1'b0;
            mcnt         <= 0;
            dcnt         <= 0;
        end else if (model_active) begin
            if (mcnt == 1) begin
                model_active <= 1'b0;
                model_done   <= 1'b1;
                dcnt         <= 2;
            end
            mcnt <= mcnt - 1;
        end else if (model_done) begin
            if (dcnt == 1) model_done <= 1'b0;
            dcnt <= dcnt - 1;
        end else if (bus.o_Tx_DV) begin
            model_active <= 1'b1;
            mcnt         <= model_len;
        end
    end

    // DV monitor: logs bytes, flags DV while transmitter busy, flags multi-cycle DV
    always @(negedge osc_clk) begin
        if (bus.o_Tx_DV) begin
            byte_log[7'(dv_total)] = bus.o_Tx_Byte;
            dv_total = dv_total + 1;
            if (bus.i_Tx_Done || bus.i_Tx_Active) viol_total = viol_total + 1;
            if (dv_prev) long_total = long_total + 1;
        end
        dv_prev = bus.o_Tx_DV;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_Wr_En = 1'b0;
        bus.i_Wr_Byte = 8'h00;
        tick(2);
        total++; if (bus.o_Count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.o_Count); end
        total++; if (bus.o_Empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.o_Empty); end
        total++; if (bus.o_Full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.o_Full); end
        total++; if (bus.o_Tx_DV !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", bus.o_Tx_DV); end
        total++; if (bus.o_Tx_Byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", bus.o_Tx_Byte); end
        total++; if (bus.o_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.o_Busy); end
`ifdef UART_TX_FIFO_OVF_CNT_EN
        total++; if (bus.o_Ovf_Count !== 8'h00) begin bad++; $display("FAIL reset_ovf got=%h exp=00", bus.o_Ovf_Count); end
`endif
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        int d0;
        d0 = dv_total;
        bus.i_Wr_Byte = 8'h55;
        bus.i_Wr_En = 1'b1;
        tick(1);
        bus.i_Wr_En = 1'b0;
        total++; if (bus.o_Count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", bus.o_Count); end
        total++; if (bus.o_Tx_DV !== 1'b0) begin bad++; $display("FAIL single_dv_early got=%b exp=0", bus.o_Tx_DV); end
        tick(1);
        total++; if (bus.o_Tx_DV !== 1'b1) begin bad++; $display("FAIL single_dv got=%b exp=1", bus.o_Tx_DV); end
        total++; if (bus.o_Tx_Byte !== 8'h55) begin bad++; $display("FAIL single_byte got=%h exp=55", bus.o_Tx_Byte); end
        total++; if (bus.o_Count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", bus.o_Count); end
        total++; if (bus.o_Busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.o_Busy); end
        tick(1);
        total++; if (bus.o_Tx_DV !== 1'b0) begin bad++; $display("FAIL single_dv_fall got=%b exp=0", bus.o_Tx_DV); end
        man_active = 1'b1;
        tick(3);
        man_active = 1'b0;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(2);
        total++; if (bus.o_Busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", bus.o_Busy); end
        total++; if (dv_total - d0 != 1) begin bad++; $display("FAIL single_dv_count got=%0d exp=1", dv_total - d0); end
        total++; if (bus.o_Tx_Byte !== 8'h55) begin bad++; $display("FAIL single_byte_hold got=%h exp=55", bus.o_Tx_Byte); end
    endtask

    task automatic test_back_to_back();
        int d0, v0, l0;
        logic ok;
        logic [7:0] exp_b;
        d0 = dv_total; v0 = viol_total; l0 = long_total;
        model_len = 11550;
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_Wr_Byte = 8'h01 + 8'(i);
            bus.i_Wr_En = 1'b1;
            tick(1);
        end
        bus.i_Wr_En = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            if (dv_total - d0 == 4 && bus.o_Empty && !bus.o_Busy && !model_active && !model_done) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=dv%0d exp=4 idle within 60000 cycles", dv_total - d0); end
        tick(5);
        total++; if (dv_total - d0 != 4) begin bad++; $display("FAIL b2b_dv_count got=%0d exp=4", dv_total - d0); end
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h01 + 8'(i);
            total++; if (byte_log[7'(d0 + i)] !== exp_b) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, byte_log[7'(d0 + i)], exp_b); end
        end
        total++; if (viol_total != v0) begin bad++; $display("FAIL b2b_dv_while_busy got=%0d exp=0", viol_total - v0); end
        total++; if (long_total != l0) begin bad++; $display("FAIL b2b_dv_width got=%0d exp=0", long_total - l0); end
        model_en = 1'b0;
        model_len = 4;
    endtask

    task automatic test_overflow();
        int d0;
        logic ok;
        logic [7:0] exp_b;
        d0 = dv_total;
        man_active = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.i_Wr_Byte = 8'h10 + 8'(i);
            bus.i_Wr_En = 1'b1;
            tick(1);
            if (i == 15) begin
                total++; if (bus.o_Full !== 1'b1) begin bad++; $display("FAIL ovf_full16 got=%b exp=1", bus.o_Full); end
            end
        end
        bus.i_Wr_En = 1'b0;
        total++; if (bus.o_Count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.o_Count); end
        total++; if (bus.o_Full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", bus.o_Full); end
        total++; if (bus.o_Empty !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", bus.o_Empty); end
        total++; if (dv_total != d0) begin bad++; $display("FAIL ovf_no_dv got=%0d exp=0", dv_total - d0); end
`ifdef UART_TX_FIFO_OVF_CNT_EN
        total++; if (bus.o_Ovf_Count !== 8'h01) begin bad++; $display("FAIL ovf_counter got=%h exp=01", bus.o_Ovf_Count); end
`endif
        man_active = 1'b0;
        model_en = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (bus.o_Empty && !bus.o_Busy && !model_active && !model_done) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        total++; if (!ok) begin bad++; $display("FAIL ovf_drain_timeout got=count%0d exp=empty", bus.o_Count); end
        total++; if (dv_total - d0 != 16) begin bad++; $display("FAIL ovf_drain_count got=%0d exp=16", dv_total - d0); end
        for (int i = 0; i < 16; i++) begin
            exp_b = 8'h10 + 8'(i);
            total++; if (byte_log[7'(d0 + i)] !== exp_b) begin bad++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, byte_log[7'(d0 + i)], exp_b); end
        end
        model_en = 1'b0;
    endtask

    task automatic test_same_cycle();
        int d0;
        logic ok;
        logic [7:0] exp_b;
        man_active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.i_Wr_Byte = 8'hA0 + 8'(i);
            bus.i_Wr_En = 1'b1;
            tick(1);
        end
        bus.i_Wr_En = 1'b0;
        total++; if (bus.o_Count !== 5'd5) begin bad++; $display("FAIL same_pre_count got=%0d exp=5", bus.o_Count); end
        d0 = dv_total;
        man_active = 1'b0;
        bus.i_Wr_Byte = 8'hA5;
        bus.i_Wr_En = 1'b1;
        tick(1);
        bus.i_Wr_En = 1'b0;
        total++; if (bus.o_Count !== 5'd5) begin bad++; $display("FAIL same_count got=%0d exp=5", bus.o_Count); end
        total++; if (bus.o_Tx_DV !== 1'b1) begin bad++; $display("FAIL same_dv got=%b exp=1", bus.o_Tx_DV); end
        total++; if (bus.o_Tx_Byte !== 8'hA0) begin bad++; $display("FAIL same_byte got=%h exp=a0", bus.o_Tx_Byte); end
        tick(1);
        man_active = 1'b1;
        tick(1);
        man_active = 1'b0;
        man_done = 1'b1;
        tick(1);
        model_en = 1'b1;
        man_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.i_Wr_Byte = 8'hA6 + 8'(i);
            bus.i_Wr_En = 1'b1;
            tick(1);
        end
        bus.i_Wr_En = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (bus.o_Empty && !bus.o_Busy && !model_active && !model_done) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=count%0d exp=empty", bus.o_Count); end
        total++; if (dv_total - d0 != 18) begin bad++; $display("FAIL wrap_dv_count got=%0d exp=18", dv_total - d0); end
        for (int i = 0; i < 18; i++) begin
            exp_b = 8'hA0 + 8'(i);
            total++; if (byte_log[7'(d0 + i)] !== exp_b) begin bad++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, byte_log[7'(d0 + i)], exp_b); end
        end
        total++; if (bus.o_Count !== 5'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", bus.o_Count); end
        model_en = 1'b0;
    endtask

    task automatic test_done_hold();
        int d0;
        d0 = dv_total;
        man_active = 1'b1;
        bus.i_Wr_Byte = 8'h3C;
        bus.i_Wr_En = 1'b1;
        tick(1);
        bus.i_Wr_En = 1'b0;
        man_active = 1'b0;
        man_done = 1'b1;
        tick(1);
        total++; if (bus.o_Tx_DV !== 1'b0) begin bad++; $display("FAIL hold_dv_a got=%b exp=0", bus.o_Tx_DV); end
        tick(1);
        total++; if (bus.o_Tx_DV !== 1'b0) begin bad++; $display("FAIL hold_dv_b got=%b exp=0", bus.o_Tx_DV); end
        man_done = 1'b0;
        tick(1);
        total++; if (bus.o_Tx_DV !== 1'b1) begin bad++; $display("FAIL hold_dv_after got=%b exp=1", bus.o_Tx_DV); end
        total++; if (bus.o_Tx_Byte !== 8'h3C) begin bad++; $display("FAIL hold_byte got=%h exp=3c", bus.o_Tx_Byte); end
        tick(1);
        man_active = 1'b1;
        tick(2);
        man_active = 1'b0;
        man_done = 1'b1;
        tick(2);
        man_done = 1'b0;
        tick(2);
        total++; if (dv_total - d0 != 1) begin bad++; $display("FAIL hold_dv_count got=%0d exp=1", dv_total - d0); end
        total++; if (bus.o_Busy !== 1'b0) begin bad++; $display("FAIL hold_idle got=%b exp=0", bus.o_Busy); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bus.i_Wr_Byte = 8'h77;
        bus.i_Wr_En = 1'b1;
        tick(1);
        bus.i_Wr_En = 1'b0;
        tick(2);
        man_active = 1'b1;
        bus.i_Wr_Byte = 8'h88;
        bus.i_Wr_En = 1'b1;
        tick(1);
        bus.i_Wr_Byte = 8'h89;
        tick(1);
        bus.i_Wr_En = 1'b0;
        total++; if (bus.o_Busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre got=%b exp=1", bus.o_Busy); end
        total++; if (bus.o_Count !== 5'd2) begin bad++; $display("FAIL rmid_count_pre got=%0d exp=2", bus.o_Count); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_Count !== 5'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", bus.o_Count); end
        total++; if (bus.o_Empty !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%b exp=1", bus.o_Empty); end
        total++; if (bus.o_Full !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b exp=0", bus.o_Full); end
        total++; if (bus.o_Tx_DV !== 1'b0) begin bad++; $display("FAIL rmid_dv got=%b exp=0", bus.o_Tx_DV); end
        total++; if (bus.o_Tx_Byte !== 8'h00) begin bad++; $display("FAIL rmid_byte got=%h exp=00", bus.o_Tx_Byte); end
        total++; if (bus.o_Busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.o_Busy); end
`ifdef UART_TX_FIFO_OVF_CNT_EN
        total++; if (bus.o_Ovf_Count !== 8'h00) begin bad++; $display("FAIL rmid_ovf got=%h exp=00", bus.o_Ovf_Count); end
`endif
        tick(2);
        rst_n = 1'b1;
        d0 = dv_total;
        bus.i_Wr_Byte = 8'h99;
        bus.i_Wr_En = 1'b1;
        tick(1);
        bus.i_Wr_En = 1'b0;
        tick(3);
        total++; if (dv_total != d0) begin bad++; $display("FAIL rmid_dv_while_active got=%0d exp=0", dv_total - d0); end
        total++; if (bus.o_Count !== 5'd1) begin bad++; $display("FAIL rmid_count_post got=%0d exp=1", bus.o_Count); end
        man_active = 1'b0;
        man_done = 1'b1;
        tick(2);
        total++; if (dv_total != d0) begin bad++; $display("FAIL rmid_dv_while_done got=%0d exp=0", dv_total - d0); end
        man_done = 1'b0;
        tick(1);
        total++; if (bus.o_Tx_DV !== 1'b1) begin bad++; $display("FAIL rmid_dv_release got=%b exp=1", bus.o_Tx_DV); end
        total++; if (bus.o_Tx_Byte !== 8'h99) begin bad++; $display("FAIL rmid_byte_release got=%h exp=99", bus.o_Tx_Byte); end
        tick(1);
        man_active = 1'b1;
        tick(2);
        man_active = 1'b0;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(2);
        total++; if (bus.o_Busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b exp=0", bus.o_Busy); end
        total++; if (bus.o_Empty !== 1'b1) begin bad++; $display("FAIL rmid_empty_end got=%b exp=1", bus.o_Empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_same_cycle();
        test_done_hold();
        test_reset_mid();
        total++; if (long_total != 0) begin bad++; $display("FAIL dv_pulse_width got=%0d exp=0", long_total); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
